// File: rtl/arith120_pkg.sv
// arith120_pkg: shared constants and FSM state type for the 120-bit sliced arithmetic blocks
package arith120_pkg;
  localparam int WIDTH  = 120;
  localparam int SLICE  = 16;
  localparam int NSLICE = 8;
  localparam int TOP_W  = 8;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/sub_slice16.sv
// sub_slice16: combinational 16-bit subtract with borrow
// ports: a, b (16b operands), bin (borrow in) -> d (a - b - bin mod 2^16), bout (borrow out)
module sub_slice16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        bin,
  output logic [15:0] d,
  output logic        bout
);
  assign {bout, d} = {1'b0, a} - {1'b0, b} - 17'(bin);
endmodule

// File: rtl/sub120_seq.sv
// sub120_seq: sequential 120-bit subtractor, one slice per cycle (7 x 16b + 1 x 8b)
// ports: clk, rst_n (sync, active-low); in_valid/in_ready + a, b, borrow_in operand handshake;
//        out_valid/out_ready + diff, borrow_out result handshake
module sub120_seq
  import arith120_pkg::*;
#(
  parameter int WIDTH = 120,
  parameter int SLICE = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);
  state_t state, nxt;
  logic [2:0] idx;
  logic br, bo, bw, last;
  logic [WIDTH-1:0] a_r, b_r;
  logic [NSLICE*SLICE-1:0] a_ext, b_ext;
  logic [15:0] a_s, b_s, d;
  logic [6:0] off;
  assign off   = 7'(idx * SLICE);
  assign last  = idx == 3'(NSLICE - 1);
  // zero-extending to 8 full slices makes the top slice's upper 8 bits zero
  assign a_ext = (NSLICE*SLICE)'(a_r);
  assign b_ext = (NSLICE*SLICE)'(b_r);
  assign a_s   = a_ext[off +: 16];
  assign b_s   = b_ext[off +: 16];
  // on the 8-bit top slice the borrow shows up at bit 8 of the extended difference
  assign bw    = last ? d[TOP_W] : bo;
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  sub_slice16 u_slice (.a(a_s), .b(b_s), .bin(br), .d(d), .bout(bo));
  always_ff @(posedge clk) state <= rst_n ? nxt : IDLE;
  always_comb begin
    nxt = state;
    if (state == IDLE && in_valid) nxt = RUN;
    if (state == RUN && last) nxt = DONE;
    if (state == DONE && out_ready) nxt = IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx        <= '0;
      br         <= 1'b0;
      a_r        <= '0;
      b_r        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      a_r <= a;
      b_r <= b;
      br  <= borrow_in;
      idx <= '0;
    end else if (state == RUN) begin
      if (last) diff[WIDTH-1 -: TOP_W] <= d[TOP_W-1:0];
      else diff[off +: 16] <= d;
      br         <= bw;
      idx        <= idx + 3'd1;
      borrow_out <= last ? bw : borrow_out;
    end
  end
endmodule

// File: tb/tb_sub120_seq.sv
// tb_sub120_seq: directed self-checking bench with a cycle-level behavioural model of sub120_seq
module tb_sub120_seq;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0, borrow_in = 1'b0;
  logic [119:0] a = '0, b = '0;
  logic in_ready, out_valid, borrow_out;
  logic [119:0] diff;
  int n_cmp = 0, n_bad = 0;
  logic chk_en = 1'b0;
  int busy = 0;
  logic have = 1'b0, eb = 1'b0;
  logic [119:0] ed = '0;
  logic [120:0] full;

  sub120_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .borrow_in(borrow_in), .out_valid(out_valid), .out_ready(out_ready), .diff(diff),
    .borrow_out(borrow_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [119:0] act, input logic [119:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // model: an accepted operation is busy for 8 edges, then the result waits for out_ready
  always @(posedge clk) begin
    if (!rst_n) begin
      busy = 0; have = 1'b0; ed = '0; eb = 1'b0;
    end else if (have) begin
      if (out_ready) have = 1'b0;
    end else if (busy > 0) begin
      busy--;
      if (busy == 0) have = 1'b1;
    end else if (in_valid) begin
      full = {1'b0, a} - {1'b0, b} - 121'(borrow_in);
      ed = full[119:0];
      eb = full[120];
      busy = 8;
    end
  end

  always @(negedge clk) if (chk_en) begin
    chk("in_ready", 120'(in_ready), 120'(!(busy > 0 || have)));
    chk("out_valid", 120'(out_valid), 120'(have));
    if (busy == 0) begin
      chk("diff", diff, ed);
      chk("borrow_out", 120'(borrow_out), 120'(eb));
    end
  end

  task automatic run_op(input logic [119:0] ia, input logic [119:0] ib, input logic ibin,
                        input logic [119:0] xd, input logic xb, input int hold);
    int lat;
    @(negedge clk);
    a = ia; b = ib; borrow_in = ibin; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; a = ~ia; b = ~ib;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 120'(lat), 120'd8);
    chk("lit_diff", diff, xd);
    chk("lit_borrow", 120'(borrow_out), 120'(xb));
    chk("model_diff", ed, xd);
    chk("model_borrow", 120'(eb), 120'(xb));
    in_valid = 1'b1;
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", 120'(out_valid), 120'd1);
      chk("hold_ready", 120'(in_ready), 120'd0);
      chk("hold_diff", diff, xd);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("back_idle", 120'(in_ready), 120'd1);
  endtask

  initial begin
    int last_v, period;
    logic prev;
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    chk("rst_ready", 120'(in_ready), 120'd1);
    chk("rst_valid", 120'(out_valid), 120'd0);
    chk("rst_diff", diff, 120'd0);
    rst_n = 1'b1;
    run_op(120'd5, 120'd3, 1'b0, 120'd2, 1'b0, 0);
    run_op(120'd0, 120'd1, 1'b0, {120{1'b1}}, 1'b1, 0);
    run_op(120'h1_0000, 120'd1, 1'b0, 120'hFFFF, 1'b0, 0);
    run_op(120'd1 << 112, 120'd1 << 111, 1'b1, (120'd1 << 111) - 120'd1, 1'b0, 0);
    run_op(120'h1234_5678_9abc_def0_1122_3344_5566, 120'h1234_5678_9abc_def0_1122_3344_5566,
           1'b0, 120'd0, 1'b0, 5);
    run_op(120'd0, 120'd0, 1'b1, {120{1'b1}}, 1'b1, 0);
    run_op({120{1'b1}}, 120'd0, 1'b0, {120{1'b1}}, 1'b0, 2);
    run_op(120'd1 << 119, 120'd1 << 16, 1'b0, (120'd1 << 119) - (120'd1 << 16), 1'b0, 0);
    // reset at the edge where slice 3 is computed
    @(negedge clk);
    a = 120'd77; b = 120'd7; borrow_in = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_ready", 120'(in_ready), 120'd1);
    chk("abort_valid", 120'(out_valid), 120'd0);
    chk("abort_diff", diff, 120'd0);
    run_op(120'd100, 120'd58, 1'b1, 120'd41, 1'b0, 0);
    // throughput with out_ready tied high
    @(negedge clk);
    a = 120'd9; b = 120'd4; borrow_in = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    last_v = -1; period = 0; prev = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid && !prev) begin
        if (last_v >= 0) period = i - last_v;
        last_v = i;
      end
      prev = out_valid;
    end
    chk("throughput", 120'(period), 120'd10);
    in_valid = 1'b0; out_ready = 1'b0;
    repeat (12) @(negedge clk);
    chk("final_diff", diff, 120'd5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
